// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side and memory-side handshake signals around mem_arbiter.
// The master modport is the arbiter's view; slave is the view of whatever surrounds it.
interface mem_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic            i_ifu_req;
  logic [AW-1:0]   i_ifu_addr;
  logic            o_ifu_gnt;
  logic            o_ifu_rvalid;
  logic [DW-1:0]   o_ifu_rdata;

  logic            i_lsu_req;
  logic [AW-1:0]   i_lsu_addr;
  logic            i_lsu_wen;
  logic [DW-1:0]   i_lsu_wdata;
  logic [DW/8-1:0] i_lsu_wstrb;
  logic            o_lsu_gnt;
  logic            o_lsu_rvalid;
  logic [DW-1:0]   o_lsu_rdata;

  logic            o_mem_req;
  logic [AW-1:0]   o_mem_addr;
  logic            o_mem_wen;
  logic [DW-1:0]   o_mem_wdata;
  logic [DW/8-1:0] o_mem_wstrb;
  logic            i_mem_gnt;
  logic            i_mem_rvalid;
  logic [DW-1:0]   i_mem_rdata;

  modport master (
    input  i_ifu_req, i_ifu_addr,
    output o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata,
    input  i_lsu_req, i_lsu_addr, i_lsu_wen, i_lsu_wdata, i_lsu_wstrb,
    output o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
    output o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wstrb,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    output i_ifu_req, i_ifu_addr,
    input  o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata,
    output i_lsu_req, i_lsu_addr, i_lsu_wen, i_lsu_wdata, i_lsu_wstrb,
    input  o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
    input  o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wstrb,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one external memory port between IFU and LSU, one transaction in flight,
// LSU priority with a bounded number of LSU wins over a waiting IFU.
module mem_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.master bus,
  output logic          o_busy,
  output logic          o_owner,
  output logic          o_err
);
  localparam int              WCW      = $clog2(STARVE_MAX + 1);
  localparam logic [WCW-1:0]  WAIT_LIM = WCW'(STARVE_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]     state_q, state_d;
  logic           owner_q, owner_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           err_q, err_d;

  logic in_req, in_rsp;
  logic any_req, lsu_wins, arb_en;
  logic ifu_rvalid, lsu_rvalid;

  assign in_req  = (state_q == S_REQ);
  assign in_rsp  = (state_q == S_RSP);
  assign any_req = bus.i_ifu_req | bus.i_lsu_req;

  // LSU has priority until it has beaten a waiting IFU STARVE_MAX times in a row.
  assign lsu_wins = bus.i_lsu_req & (~bus.i_ifu_req | (wait_cnt_q < WAIT_LIM));

  // Arbitration happens from IDLE or in the response cycle, enabling back-to-back.
  assign arb_en = any_req & ((state_q == S_IDLE) | (in_rsp & bus.i_mem_rvalid));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q | (bus.i_mem_rvalid & ~in_rsp);

    case (state_q)
      S_IDLE:  if (any_req) state_d = S_REQ;
      S_REQ:   if (bus.i_mem_gnt) state_d = S_RSP;
      S_RSP:   if (bus.i_mem_rvalid) state_d = any_req ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (arb_en) begin
      owner_d = lsu_wins ? OWN_LSU : OWN_IFU;
      if (!lsu_wins) begin
        wait_cnt_d = '0;
      end else if (bus.i_ifu_req && (wait_cnt_q != WAIT_LIM)) begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IFU;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Downstream payload follows the live inputs of the latched owner while in REQ.
  always_comb begin
    bus.o_mem_req   = in_req;
    bus.o_mem_addr  = '0;
    bus.o_mem_wen   = 1'b0;
    bus.o_mem_wdata = '0;
    bus.o_mem_wstrb = '0;
    if (in_req) begin
      if (owner_q == OWN_LSU) begin
        bus.o_mem_addr  = bus.i_lsu_addr;
        bus.o_mem_wen   = bus.i_lsu_wen;
        bus.o_mem_wdata = bus.i_lsu_wdata;
        bus.o_mem_wstrb = bus.i_lsu_wstrb;
      end else begin
        bus.o_mem_addr  = bus.i_ifu_addr;
      end
    end
  end

  assign bus.o_ifu_gnt = in_req & (owner_q == OWN_IFU) & bus.i_mem_gnt;
  assign bus.o_lsu_gnt = in_req & (owner_q == OWN_LSU) & bus.i_mem_gnt;

  assign ifu_rvalid = in_rsp & (owner_q == OWN_IFU) & bus.i_mem_rvalid;
  assign lsu_rvalid = in_rsp & (owner_q == OWN_LSU) & bus.i_mem_rvalid;

  assign bus.o_ifu_rvalid = ifu_rvalid;
  assign bus.o_lsu_rvalid = lsu_rvalid;
  assign bus.o_ifu_rdata  = ifu_rvalid ? bus.i_mem_rdata : '0;
  assign bus.o_lsu_rdata  = lsu_rvalid ? bus.i_mem_rdata : '0;

  assign o_busy  = (state_q != S_IDLE);
  assign o_owner = owner_q;
  assign o_err   = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a memory/requester reference model.
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy, owner, err;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_busy (busy),
    .o_owner(owner),
    .o_err  (err)
  );

  task automatic clear_inputs();
    bus.i_ifu_req    = 1'b0;
    bus.i_ifu_addr   = '0;
    bus.i_lsu_req    = 1'b0;
    bus.i_lsu_addr   = '0;
    bus.i_lsu_wen    = 1'b0;
    bus.i_lsu_wdata  = '0;
    bus.i_lsu_wstrb  = '0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [DW/8-1:0] ws);
    logic [DW-1:0] res;
    res = old;
    for (int b = 0; b < DW/8; b++) if (ws[b]) res[b*8 +: 8] = wd[b*8 +: 8];
    return res;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_ifu_req = 1'b1;
    bus.i_lsu_req = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (bus.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b want 0", bus.o_mem_req); end
    n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %0b want 0", owner); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
    n_checks++; if ({bus.o_ifu_gnt, bus.o_lsu_gnt, bus.o_ifu_rvalid, bus.o_lsu_rvalid} !== 4'b0)
      begin n_fail++; $display("FAIL reset_handshakes: got %b want 0000",
        {bus.o_ifu_gnt, bus.o_lsu_gnt, bus.o_ifu_rvalid, bus.o_lsu_rvalid}); end
    n_checks++; if (bus.o_mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.o_mem_addr); end
    rst = 1'b0;
    clear_inputs();
    $display("txn reset done");
  endtask

  task automatic test_ifu_alone();
    do_reset();
    bus.i_ifu_req  = 1'b1;
    bus.i_ifu_addr = 64'h8000_0000;
    #1;
    n_checks++; if (bus.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL ifu_c0_mem_req: got %0b want 0", bus.o_mem_req); end
    @(negedge clk);
    bus.i_mem_gnt = 1'b1;
    #1;
    n_checks++; if (bus.o_mem_req !== 1'b1) begin n_fail++; $display("FAIL ifu_c1_mem_req: got %0b want 1", bus.o_mem_req); end
    n_checks++; if (bus.o_ifu_gnt !== 1'b1 || bus.o_lsu_gnt !== 1'b0)
      begin n_fail++; $display("FAIL ifu_c1_gnt: got ifu=%0b lsu=%0b want 1/0", bus.o_ifu_gnt, bus.o_lsu_gnt); end
    n_checks++; if (bus.o_mem_addr !== 64'h8000_0000 || bus.o_mem_wen !== 1'b0 || bus.o_mem_wstrb !== '0 || bus.o_mem_wdata !== '0)
      begin n_fail++; $display("FAIL ifu_c1_payload: got addr=%h wen=%0b want 80000000/0", bus.o_mem_addr, bus.o_mem_wen); end
    @(negedge clk);
    bus.i_ifu_req = 1'b0;
    bus.i_mem_gnt = 1'b0;
    #1;
    n_checks++; if (bus.o_mem_req !== 1'b0 || bus.o_ifu_rvalid !== 1'b0)
      begin n_fail++; $display("FAIL ifu_c2_idle_bus: got req=%0b rvalid=%0b want 0/0", bus.o_mem_req, bus.o_ifu_rvalid); end
    @(negedge clk);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'h0000_0413;
    #1;
    n_checks++; if (bus.o_ifu_rvalid !== 1'b1 || bus.o_ifu_rdata !== 64'h0000_0413)
      begin n_fail++; $display("FAIL ifu_c3_rsp: got rvalid=%0b data=%h want 1/413", bus.o_ifu_rvalid, bus.o_ifu_rdata); end
    n_checks++; if (bus.o_lsu_rvalid !== 1'b0 || bus.o_lsu_rdata !== '0)
      begin n_fail++; $display("FAIL ifu_c3_lsu_quiet: got rvalid=%0b data=%h want 0/0", bus.o_lsu_rvalid, bus.o_lsu_rdata); end
    $display("txn ifu_alone addr=80000000 data=%h", bus.o_ifu_rdata);
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ifu_c4_busy: got %0b want 0", busy); end
  endtask

  task automatic test_lsu_write();
    int pulses;
    do_reset();
    bus.i_lsu_req   = 1'b1;
    bus.i_lsu_addr  = 64'h8000_1000;
    bus.i_lsu_wen   = 1'b1;
    bus.i_lsu_wstrb = 8'h0F;
    bus.i_lsu_wdata = 64'hDEAD_BEEF;
    @(negedge clk);
    bus.i_mem_gnt = 1'b1;
    #1;
    n_checks++; if (bus.o_mem_addr !== 64'h8000_1000 || bus.o_mem_wen !== 1'b1 ||
                    bus.o_mem_wstrb !== 8'h0F || bus.o_mem_wdata !== 64'hDEAD_BEEF)
      begin n_fail++; $display("FAIL lsu_wr_payload: got addr=%h wen=%0b strb=%h data=%h want 80001000/1/0f/deadbeef",
        bus.o_mem_addr, bus.o_mem_wen, bus.o_mem_wstrb, bus.o_mem_wdata); end
    n_checks++; if (bus.o_lsu_gnt !== 1'b1 || bus.o_ifu_gnt !== 1'b0 || owner !== 1'b1)
      begin n_fail++; $display("FAIL lsu_wr_gnt: got lsu=%0b ifu=%0b owner=%0b want 1/0/1", bus.o_lsu_gnt, bus.o_ifu_gnt, owner); end
    @(negedge clk);
    clear_inputs();
    bus.i_mem_rvalid = 1'b1;
    #1;
    pulses = int'(bus.o_lsu_rvalid);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_mem_rvalid = 1'b0;
      #1;
      pulses += int'(bus.o_lsu_rvalid);
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL lsu_wr_ack_count: got %0d want 1", pulses); end
    $display("txn lsu_write addr=80001000 acks=%0d", pulses);
  endtask

  task automatic test_contention();
    logic exp_seq [10];
    logic got_seq [10];
    int   n;
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    n = 0;
    do_reset();
    bus.i_ifu_req  = 1'b1;
    bus.i_ifu_addr = 64'h8000_0100;
    bus.i_lsu_req  = 1'b1;
    bus.i_lsu_addr = 64'h8000_3000;
    for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
      @(negedge clk);
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = 1'b0;
      #1;
      bus.i_mem_gnt    = bus.o_mem_req;
      bus.i_mem_rvalid = busy & ~bus.o_mem_req;
      bus.i_mem_rdata  = {$urandom, $urandom};
      #1;
      n_checks++; if (bus.o_ifu_gnt && bus.o_lsu_gnt) begin n_fail++; $display("FAIL contention_two_gnts: got 11 want one-hot"); end
      if (bus.o_ifu_gnt || bus.o_lsu_gnt) begin
        got_seq[n] = bus.o_lsu_gnt;
        $display("txn contention grant %0d to %s", n, bus.o_lsu_gnt ? "LSU" : "IFU");
        n++;
      end
    end
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL contention_timeout: got %0d grants want 10", n); end
    for (int i = 0; i < n; i++) begin
      n_checks++; if (got_seq[i] !== exp_seq[i])
        begin n_fail++; $display("FAIL contention_order[%0d]: got lsu=%0b want lsu=%0b", i, got_seq[i], exp_seq[i]); end
    end
    clear_inputs();
  endtask

  task automatic test_grant_stall();
    do_reset();
    bus.i_ifu_req  = 1'b1;
    bus.i_ifu_addr = 64'h8000_0040;
    @(negedge clk);
    bus.i_lsu_req  = 1'b1;
    bus.i_lsu_addr = 64'h8000_2000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++; if (owner !== 1'b0 || bus.o_mem_addr !== 64'h8000_0040 || bus.o_mem_req !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got owner=%0b addr=%h req=%0b want 0/80000040/1", i, owner, bus.o_mem_addr, bus.o_mem_req); end
      n_checks++; if (bus.o_ifu_gnt !== 1'b0 || bus.o_lsu_gnt !== 1'b0)
        begin n_fail++; $display("FAIL stall_no_gnt[%0d]: got ifu=%0b lsu=%0b want 0/0", i, bus.o_ifu_gnt, bus.o_lsu_gnt); end
    end
    @(negedge clk);
    bus.i_mem_gnt = 1'b1;
    #1;
    n_checks++; if (bus.o_ifu_gnt !== 1'b1 || bus.o_lsu_gnt !== 1'b0)
      begin n_fail++; $display("FAIL stall_ifu_gnt: got ifu=%0b lsu=%0b want 1/0", bus.o_ifu_gnt, bus.o_lsu_gnt); end
    @(negedge clk);
    bus.i_ifu_req    = 1'b0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'h1111_2222_3333_4444;
    #1;
    n_checks++; if (bus.o_ifu_rvalid !== 1'b1 || bus.o_lsu_rvalid !== 1'b0 || bus.o_ifu_rdata !== 64'h1111_2222_3333_4444)
      begin n_fail++; $display("FAIL stall_ifu_rsp: got rv=%0b/%0b data=%h", bus.o_ifu_rvalid, bus.o_lsu_rvalid, bus.o_ifu_rdata); end
    $display("txn stall ifu addr=80000040 data=%h", bus.o_ifu_rdata);
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_gnt    = 1'b1;
    #1;
    n_checks++; if (bus.o_mem_req !== 1'b1 || owner !== 1'b1 || bus.o_mem_addr !== 64'h8000_2000 || bus.o_lsu_gnt !== 1'b1)
      begin n_fail++; $display("FAIL stall_lsu_b2b: got req=%0b owner=%0b addr=%h gnt=%0b want 1/1/80002000/1",
        bus.o_mem_req, owner, bus.o_mem_addr, bus.o_lsu_gnt); end
    @(negedge clk);
    bus.i_lsu_req    = 1'b0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'hCAFE_F00D_0000_0001;
    #1;
    n_checks++; if (bus.o_lsu_rvalid !== 1'b1 || bus.o_lsu_rdata !== 64'hCAFE_F00D_0000_0001 || bus.o_ifu_rvalid !== 1'b0)
      begin n_fail++; $display("FAIL stall_lsu_rsp: got rv=%0b data=%h want 1/cafef00d00000001", bus.o_lsu_rvalid, bus.o_lsu_rdata); end
    $display("txn stall lsu addr=80002000 data=%h", bus.o_lsu_rdata);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid_rsp();
    do_reset();
    bus.i_ifu_req  = 1'b1;
    bus.i_ifu_addr = 64'h8000_0080;
    @(negedge clk);
    bus.i_mem_gnt = 1'b1;
    @(negedge clk);
    bus.i_ifu_req = 1'b0;
    bus.i_mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_rsp: got busy=%0b want 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'h1234;
    #1;
    n_checks++; if (bus.o_ifu_rvalid !== 1'b0 || bus.o_lsu_rvalid !== 1'b0 || bus.o_ifu_rdata !== '0)
      begin n_fail++; $display("FAIL rstmid_forward: got rv=%0b/%0b data=%h want 0/0/0", bus.o_ifu_rvalid, bus.o_lsu_rvalid, bus.o_ifu_rdata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got busy=%0b want 0", busy); end
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_gnt    = 1'b1;
    #1;
    n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got err=%0b busy=%0b want 1/0", err, busy); end
    @(negedge clk);
    bus.i_mem_gnt = 1'b0;
    #1;
    n_checks++; if (err !== 1'b1 || busy !== 1'b0 || bus.o_ifu_gnt !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_sticky: got err=%0b busy=%0b gnt=%0b want 1/0/0", err, busy, bus.o_ifu_gnt); end
    $display("txn reset_mid_rsp err=%0b", err);
    do_reset();
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err_clear: got %0b want 0", err); end
  endtask

  task automatic test_random();
    logic [DW-1:0]   mem_m  [8];
    logic [DW-1:0]   golden [8];
    logic            ifu_pend, ifu_wait, lsu_pend, lsu_wait;
    logic [2:0]      ifu_idx, lsu_idx, m_idx;
    logic            lsu_w, m_wen;
    logic [DW-1:0]   lsu_wd, m_wd, drv_rdata;
    logic [DW/8-1:0] lsu_ws, m_ws;
    logic            m_busy, gnt, rv, done;
    int              m_cnt, starve, n_txn;
    logic            exp_owner, prev_ifu, prev_lsu, prev_mreq, lsu_won;
    logic [AW-1:0]   ifu_a, lsu_a;

    for (int i = 0; i < 8; i++) begin
      mem_m[i]  = {$urandom, $urandom};
      golden[i] = mem_m[i];
    end
    ifu_pend = 0; ifu_wait = 0; lsu_pend = 0; lsu_wait = 0;
    ifu_idx = 0; lsu_idx = 0; m_idx = 0; lsu_w = 0; m_wen = 0;
    lsu_wd = '0; m_wd = '0; lsu_ws = '0; m_ws = '0;
    m_busy = 0; m_cnt = 0; starve = 0; n_txn = 0; done = 0;
    exp_owner = 0; prev_ifu = 0; prev_lsu = 0; prev_mreq = 0;
    do_reset();

    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (cyc >= 700 && !ifu_pend && !ifu_wait && !lsu_pend && !lsu_wait && !m_busy) begin
        done = 1;
        break;
      end
      if (cyc > 0) @(negedge clk);

      // requesters: hold request until granted, one outstanding each
      if (cyc < 700 && !ifu_pend && !ifu_wait && $urandom_range(0, 2) == 0) begin
        ifu_pend = 1;
        ifu_idx  = 3'($urandom_range(0, 7));
      end
      if (cyc < 700 && !lsu_pend && !lsu_wait && $urandom_range(0, 2) == 0) begin
        lsu_pend = 1;
        lsu_idx  = 3'($urandom_range(0, 7));
        lsu_w    = 1'($urandom_range(0, 1));
        lsu_wd   = {$urandom, $urandom};
        lsu_ws   = 8'($urandom_range(1, 255));
      end
      ifu_a = 64'h8000_0000 + AW'(ifu_idx) * 8;
      lsu_a = 64'h8000_0000 + AW'(lsu_idx) * 8;
      bus.i_ifu_req   = ifu_pend;
      bus.i_ifu_addr  = ifu_pend ? ifu_a : '0;
      bus.i_lsu_req   = lsu_pend;
      bus.i_lsu_addr  = lsu_pend ? lsu_a : '0;
      bus.i_lsu_wen   = lsu_pend & lsu_w;
      bus.i_lsu_wdata = lsu_pend ? lsu_wd : '0;
      bus.i_lsu_wstrb = lsu_pend ? lsu_ws : '0;
      #1;

      // memory model and arbitration reference
      gnt = 0; rv = 0; drv_rdata = '0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          rv = 1;
          if (m_wen) begin
            mem_m[m_idx] = merge(mem_m[m_idx], m_wd, m_ws);
            drv_rdata    = {$urandom, $urandom};
          end else begin
            drv_rdata = mem_m[m_idx];
          end
          m_busy = 0;
        end else begin
          m_cnt--;
        end
      end else if (bus.o_mem_req) begin
        if (!prev_mreq) begin
          // LSU first, unless it already beat a waiting IFU STARVE_MAX times running
          lsu_won   = prev_lsu && (!prev_ifu || starve < STARVE_MAX);
          exp_owner = lsu_won;
          if (lsu_won && prev_ifu) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
          else if (!lsu_won) starve = 0;
          n_checks++; if (!(prev_ifu || prev_lsu)) begin n_fail++; $display("FAIL rand_spurious_req: cycle %0d got mem_req with no request", cyc); end
          n_checks++; if (owner !== exp_owner) begin n_fail++; $display("FAIL rand_owner: cycle %0d got %0b want %0b", cyc, owner, exp_owner); end
        end
        if ($urandom_range(0, 1) == 1) begin
          gnt    = 1;
          m_idx  = bus.o_mem_addr[5:3];
          m_wen  = bus.o_mem_wen;
          m_wd   = bus.o_mem_wdata;
          m_ws   = bus.o_mem_wstrb;
          m_busy = 1;
          m_cnt  = $urandom_range(0, 2);
        end
      end
      bus.i_mem_gnt    = gnt;
      bus.i_mem_rvalid = rv;
      bus.i_mem_rdata  = drv_rdata;
      #1;

      n_checks++; if (bus.o_ifu_gnt !== (gnt && !exp_owner) || bus.o_lsu_gnt !== (gnt && exp_owner))
        begin n_fail++; $display("FAIL rand_gnt: cycle %0d got ifu=%0b lsu=%0b want %0b/%0b", cyc,
          bus.o_ifu_gnt, bus.o_lsu_gnt, gnt && !exp_owner, gnt && exp_owner); end
      if (gnt) begin
        if (!exp_owner) begin
          n_checks++; if (bus.o_mem_addr !== ifu_a || bus.o_mem_wen !== 1'b0 || bus.o_mem_wstrb !== '0 || bus.o_mem_wdata !== '0)
            begin n_fail++; $display("FAIL rand_ifu_payload: cycle %0d got addr=%h wen=%0b want %h/0", cyc, bus.o_mem_addr, bus.o_mem_wen, ifu_a); end
          ifu_pend = 0; ifu_wait = 1;
        end else begin
          n_checks++; if (bus.o_mem_addr !== lsu_a || bus.o_mem_wen !== lsu_w || bus.o_mem_wstrb !== lsu_ws || bus.o_mem_wdata !== lsu_wd)
            begin n_fail++; $display("FAIL rand_lsu_payload: cycle %0d got addr=%h wen=%0b strb=%h want %h/%0b/%h", cyc,
              bus.o_mem_addr, bus.o_mem_wen, bus.o_mem_wstrb, lsu_a, lsu_w, lsu_ws); end
          lsu_pend = 0; lsu_wait = 1;
        end
      end

      n_checks++; if (bus.o_ifu_rvalid !== (rv && !exp_owner) || bus.o_lsu_rvalid !== (rv && exp_owner))
        begin n_fail++; $display("FAIL rand_rvalid: cycle %0d got ifu=%0b lsu=%0b want %0b/%0b", cyc,
          bus.o_ifu_rvalid, bus.o_lsu_rvalid, rv && !exp_owner, rv && exp_owner); end
      if (rv && !exp_owner) begin
        n_checks++; if (bus.o_ifu_rdata !== golden[ifu_idx] || bus.o_lsu_rdata !== '0)
          begin n_fail++; $display("FAIL rand_ifu_rdata: cycle %0d got %h want %h", cyc, bus.o_ifu_rdata, golden[ifu_idx]); end
        $display("txn rand %0d IFU rd addr=%h data=%h", n_txn, ifu_a, bus.o_ifu_rdata);
        ifu_wait = 0; n_txn++;
      end
      if (rv && exp_owner) begin
        if (lsu_w) begin
          n_checks++; if (bus.o_lsu_rdata !== drv_rdata || bus.o_ifu_rdata !== '0)
            begin n_fail++; $display("FAIL rand_lsu_ack: cycle %0d got %h want %h", cyc, bus.o_lsu_rdata, drv_rdata); end
          golden[lsu_idx] = merge(golden[lsu_idx], lsu_wd, lsu_ws);
          $display("txn rand %0d LSU wr addr=%h data=%h strb=%h", n_txn, lsu_a, lsu_wd, lsu_ws);
        end else begin
          n_checks++; if (bus.o_lsu_rdata !== golden[lsu_idx] || bus.o_ifu_rdata !== '0)
            begin n_fail++; $display("FAIL rand_lsu_rdata: cycle %0d got %h want %h", cyc, bus.o_lsu_rdata, golden[lsu_idx]); end
          $display("txn rand %0d LSU rd addr=%h data=%h", n_txn, lsu_a, bus.o_lsu_rdata);
        end
        lsu_wait = 0; n_txn++;
      end

      prev_ifu  = bus.i_ifu_req;
      prev_lsu  = bus.i_lsu_req;
      prev_mreq = bus.o_mem_req;
    end

    n_checks++; if (!done) begin n_fail++; $display("FAIL rand_drain_timeout: got pending ifu=%0b/%0b lsu=%0b/%0b want idle",
      ifu_pend, ifu_wait, lsu_pend, lsu_wait); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %0b want 0", err); end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ifu_alone();
    test_lsu_write();
    test_contention();
    test_grant_stall();
    test_reset_mid_rsp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
